// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-resolve signals between the pipeline and the branch predictor.
// Master is the pipeline side; slave is the predictor.
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            pred_hit;
    logic            pred_taken;
    logic [XLEN-1:0] pred_next_pc;

    logic            ex_valid;
    logic            ex_branch;
    logic [XLEN-1:0] ex_pc;
    logic            ex_br_taken;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_next_pc;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output if_pc, ex_valid, ex_branch, ex_pc, ex_br_taken, ex_target,
               ex_pred_taken, ex_pred_next_pc,
        input  pred_hit, pred_taken, pred_next_pc, mispredict, redirect_pc
    );

    modport slave (
        input  if_pc, ex_valid, ex_branch, ex_pc, ex_br_taken, ex_target,
               ex_pred_taken, ex_pred_next_pc,
        output pred_hit, pred_taken, pred_next_pc, mispredict, redirect_pc
    );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal predictor with direct-mapped BTB: fetch lookup and mispredict detection.
// Latency: prediction and mispredict are combinational; table update lands at the next edge.
// Backpressure: none; one resolve per cycle is always accepted.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int XLEN    = 32
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    // Fetch-side lookup
    logic [IDX-1:0]   if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    assign if_idx = bp.if_pc[IDX+1:2];
    assign if_tag = bp.if_pc[XLEN-1:IDX+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    assign bp.pred_hit     = if_hit;
    assign bp.pred_taken   = if_hit && ctr_q[if_idx][1];
    assign bp.pred_next_pc = bp.pred_taken ? target_q[if_idx] : bp.if_pc + XLEN'(4);

    // Execute-side resolve
    logic [IDX-1:0]   ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             resolve;
    logic             ex_hit;
    logic [XLEN-1:0]  ex_seq_pc;
    logic [XLEN-1:0]  correct_pc;
    logic [1:0]       ctr_nxt;
    logic             ctr_we;
    logic             tgt_we;

    assign ex_idx     = bp.ex_pc[IDX+1:2];
    assign ex_tag     = bp.ex_pc[XLEN-1:IDX+2];
    assign resolve    = bp.ex_valid && bp.ex_branch;
    assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ex_seq_pc  = bp.ex_pc + XLEN'(4);
    assign correct_pc = bp.ex_br_taken ? bp.ex_target : ex_seq_pc;

    assign bp.mispredict  = resolve && (correct_pc != bp.ex_pred_next_pc);
    assign bp.redirect_pc = bp.mispredict ? correct_pc : ex_seq_pc;

    // A taken miss allocates at weak-taken; a not-taken miss leaves the table alone.
    always_comb begin
        ctr_nxt = ctr_q[ex_idx];
        if (!ex_hit) begin
            ctr_nxt = 2'b10;
        end else if (bp.ex_br_taken) begin
            if (ctr_q[ex_idx] != 2'b11) ctr_nxt = ctr_q[ex_idx] + 2'd1;
        end else begin
            if (ctr_q[ex_idx] != 2'b00) ctr_nxt = ctr_q[ex_idx] - 2'd1;
        end
    end

    assign ctr_we = resolve && (ex_hit || bp.ex_br_taken);
    assign tgt_we = resolve && bp.ex_br_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
        end else if (ctr_we) begin
            valid_q[ex_idx] <= 1'b1;
            ctr_q[ex_idx]   <= ctr_nxt;
        end
    end

    // Tags and targets are not reset; valid bits mask stale contents.
    always_ff @(posedge clk) begin
        if (!rst && tgt_we) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= bp.ex_target;
        end
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Bimodal branch predictor with an integrated direct-mapped branch target buffer (BTB) for the RV32I pipeline. The fetch stage looks up the current PC every cycle and gets a predicted next PC. The execute stage reports each resolved conditional branch: its actual outcome from the branch comparator, its computed target, and the prediction that fetch made for it. The block trains its table from these reports and flags mispredictions so the pipeline can flush and redirect.

## Interface
- ENTRIES, 64, number of BTB/counter entries; power of two, ≥ 4
- XLEN, 32, address width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_pc  in  XLEN  fetch-stage PC for lookup
- pred_hit  out  1  valid entry with matching tag exists for if_pc
- pred_taken  out  1  pred_hit && counter[1]
- pred_next_pc  out  XLEN  pred_taken ? stored target : if_pc + 4
- ex_valid  in  1  execute stage holds a valid instruction
- ex_branch  in  1  instruction is a conditional branch
- ex_pc  in  XLEN  PC of the execute-stage instruction
- ex_br_taken  in  1  actual outcome from the branch comparator
- ex_target  in  XLEN  computed branch target (pc + imm)
- ex_pred_taken  in  1  pred_taken carried down the pipe with the instruction
- ex_pred_next_pc  in  XLEN  pred_next_pc carried down the pipe
- mispredict  out  1  flush request
- redirect_pc  out  XLEN  correct next PC when mispredict = 1

## Operation
- Index is pc[IDX+1:2], where IDX = log2(ENTRIES). Tag is pc[XLEN-1:IDX+2]. pc[1:0] is ignored.
- Each entry holds: valid, tag, target[XLEN-1:0], and a 2-bit saturating counter (00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken).
- Lookup is purely combinational from if_pc. It reads the table state as of the last clock edge.
- A resolve event is ex_valid && ex_branch. Without a resolve event, the table does not change and mispredict = 0.
- Update on a resolve event:
  - Hit (entry valid, tag matches ex_pc):
    - Counter increments toward 11 on taken and decrements toward 00 on not-taken, saturating at both ends.
    - On taken, the target is overwritten with ex_target.
    - On not-taken, the target is unchanged.
  - Miss, taken: allocate the entry with valid = 1, tag of ex_pc, target = ex_target, counter = 10. This evicts any aliasing entry.
  - Miss, not-taken: no change to the table.
- Misprediction, combinational from the ex_* inputs:
  - correct next PC = ex_br_taken ? ex_target : ex_pc + 4
  - mispredict = resolve event && (correct next PC != ex_pred_next_pc)
  - redirect_pc = correct next PC. It is don't-care when mispredict = 0; drive ex_pc + 4 in that case.
- All PC arithmetic is modulo 2^XLEN; ex_pc + 4 wraps from 0xFFFFFFFC to 0x00000000.
- Non-branch instructions (ex_branch = 0) never train the table or flag a mispredict, even when ex_valid = 1.

## Timing
- Reset, while rst = 1 at a clock edge:
  - every valid bit clears to 0 and every counter sets to 01
  - targets and tags are left unchanged
  - within one cycle after reset: pred_hit = 0, pred_taken = 0, pred_next_pc = if_pc + 4
  - mispredict remains combinational from its inputs
- Table writes take effect at the clock edge that samples the resolve event. A lookup of the same entry in the same cycle returns the old contents; the next cycle returns the new contents.
- Prediction latency is 0 cycles (combinational). Update latency is 1 cycle.
- mispredict and redirect_pc are valid in the same cycle as the resolve event; no register is inserted.
- If rst and a resolve event occur on the same edge, reset wins and the update is discarded.
- Reset asserted mid-training discards all learned state.
- One update per cycle; there is no backpressure or stall input. The pipeline holds ex_* inputs stable and ex_valid low during stalls.

## Test plan
All scenarios use ENTRIES = 64.
1. Cold lookup: after reset, if_pc = 0x100 → pred_hit = 0, pred_taken = 0, pred_next_pc = 0x104.
2. Allocate and train:
   - Resolve ex_pc = 0x100, taken, ex_target = 0x80 → next cycle if_pc = 0x100 gives hit = 1, taken = 1, next = 0x80.
   - Two more taken resolves, then one more → counter saturates at 11; a single not-taken afterward still predicts taken (counter 10).
3. Decay: from counter 10, resolve not-taken twice → hit = 1, pred_taken = 0, next = 0x104. A further not-taken leaves the counter at 00.
4. Alias eviction and same-cycle read/write:
   - With 0x100 trained, resolve ex_pc = 0x200 taken to 0x300; in that same cycle, if_pc = 0x100 still hits with the old entry.
   - Next cycle, if_pc = 0x100 → hit = 0 and if_pc = 0x200 → next = 0x300.
   - Separately, a not-taken miss at 0x400 allocates nothing.
5. Mispredict cases:
   - ex_pc = 0x100, pred_next = 0x104, actual taken to 0x40 → mispredict = 1, redirect = 0x40.
   - pred_next = 0x80, actual taken to 0x90 → mispredict = 1, redirect = 0x90.
   - pred_next = 0x80, actual not-taken → mispredict = 1, redirect = 0x104.
   - pred_next = 0x80, actual taken to 0x80 → mispredict = 0.
   - ex_branch = 0 with mismatched inputs → mispredict = 0.
6. Reset priority: train 0x100, then assert rst together with a taken resolve at 0x180 → afterward both 0x100 and 0x180 miss.
